// File: rtl/switch_pkg.sv
// Shared types for the switch ingress path: the buffered packet word and the
// admission FSM state encoding.
package switch_pkg;

  // Payload width of a switch write-port word.
  localparam int PKT_DATA_W = 32;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [PKT_DATA_W-1:0] data;
  } pkt_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } admit_state_e;

  // Builds a packet word from its framing flags and payload.
  function automatic pkt_word_t mkWord(input logic sop, input logic eop,
                                       input logic [PKT_DATA_W-1:0] data);
    pkt_word_t w;
    w.sop  = sop;
    w.eop  = eop;
    w.data = data;
    return w;
  endfunction

endpackage

// File: rtl/pkt_word_fifo.sv
// Synchronous show-ahead FIFO of packet words with an occupancy count.
// The read word is valid whenever empty is low.
module pkt_word_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      iClk,
  input  logic      iRst_n,
  input  logic      wrEn,
  input  pkt_word_t wrWord,
  input  logic      rdEn,
  output pkt_word_t rdWord,
  output logic      empty,
  output logic [AW:0] count
);

  pkt_word_t   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic        full;
  logic        push;
  logic        pop;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign push   = wrEn && !full;
  assign pop    = rdEn && !empty;
  assign rdWord = mem[rdPtr];

  // Storage array; no reset needed because count gates every read.
  always_ff @(posedge iClk) begin
    if (push) mem[wrPtr] <= wrWord;
  end

  // Pointers and occupancy; a push and a pop together leave count unchanged.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ingress_pkt_admit.sv
// Per-port ingress admission: decides admit/drop at each SOP, repairs missing
// EOPs, and buffers admitted words so switch backpressure never splits a
// packet.
// Handshake: upstream word transfers when iVld && oRdy at a rising clock
// edge; oRdy is registered. Downstream has no ready: a word is popped when
// the buffer is non-empty and iFifoFull is low, and appears on oWr* with
// oWrVld for exactly one cycle on the following cycle.
module ingress_pkt_admit
  import switch_pkg::*;
#(
  parameter int DATA_W    = PKT_DATA_W,
  parameter int BUF_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iSop,
  input  logic              iEop,
  input  logic              iVld,
  input  logic [DATA_W-1:0] iData,
  output logic              oRdy,
  output logic              oWrSop,
  output logic              oWrEop,
  output logic              oWrVld,
  output logic [DATA_W-1:0] oWrData,
  input  logic              iFifoFull,
  input  logic              iSramAlmostFull,
  input  logic              iCntClr,
  output logic [CNT_W-1:0]  oDropCnt,
  output logic [CNT_W-1:0]  oErrCnt,
  output logic [CNT_W-1:0]  oPktCnt
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  // Three free entries cover the hold-register flush plus the word accepted
  // during the cycle oRdy takes to fall.
  localparam logic [CW-1:0] RDY_LIMIT = CW'(BUF_DEPTH - 3);

  admit_state_e state;
  admit_state_e nextState;

  logic      rdyQ;
  logic      accept;
  logic      holdVld;
  pkt_word_t holdWord;
  pkt_word_t holdNext;
  logic      holdLoad;
  logic      holdClear;
  logic      wrEn;
  pkt_word_t wrWord;
  logic      doAdmit;
  logic      incDrop;
  logic      incErr;
  logic      incPkt;

  pkt_word_t rdWord;
  logic      bufEmpty;
  logic [CW-1:0] bufCount;
  logic      pop;

  assign oRdy   = rdyQ;
  assign accept = iVld && rdyQ;
  assign pop    = !bufEmpty && !iFifoFull;

  pkt_word_fifo #(.DEPTH(BUF_DEPTH)) uBuf (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .wrEn   (wrEn),
    .wrWord (wrWord),
    .rdEn   (pop),
    .rdWord (rdWord),
    .empty  (bufEmpty),
    .count  (bufCount)
  );

  // Admission FSM state register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= nextState;
  end

  // Next state, buffer write, hold-register control and counter increments.
  always_comb begin
    nextState = state;
    wrEn      = 1'b0;
    wrWord    = holdWord;
    holdLoad  = 1'b0;
    holdClear = 1'b0;
    holdNext  = holdWord;
    doAdmit   = 1'b0;
    incDrop   = 1'b0;
    incErr    = 1'b0;
    incPkt    = 1'b0;

    // A held last word leaves on its own the cycle after it was captured.
    if (holdVld && holdWord.eop) begin
      wrEn      = 1'b1;
      holdClear = 1'b1;
    end

    case (state)
      IDLE: begin
        if (accept) begin
          if (iSop) doAdmit = 1'b1;
          else      incErr  = 1'b1;
        end
      end
      PASS: begin
        if (accept) begin
          if (iSop) begin
            // Missing EOP: close the current packet on its held word.
            wrEn       = 1'b1;
            wrWord.eop = 1'b1;
            holdClear  = 1'b1;
            incErr     = 1'b1;
            doAdmit    = 1'b1;
          end else begin
            wrEn     = 1'b1;
            holdLoad = 1'b1;
            holdNext = mkWord(1'b0, iEop, iData);
            if (iEop) nextState = IDLE;
          end
        end
      end
      DROP: begin
        if (accept) begin
          if (iSop) begin
            incErr  = 1'b1;
            doAdmit = 1'b1;
          end else if (iEop) begin
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase

    // Admission is decided only here, on an accepted SOP.
    if (doAdmit) begin
      if (iSramAlmostFull) begin
        incDrop   = 1'b1;
        nextState = iEop ? IDLE : DROP;
      end else begin
        incPkt    = 1'b1;
        holdLoad  = 1'b1;
        holdNext  = mkWord(1'b1, iEop, iData);
        nextState = iEop ? IDLE : PASS;
      end
    end
  end

  // Hold register: one word of lookahead so an EOP can be forced onto it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      holdVld  <= 1'b0;
      holdWord <= '0;
    end else if (holdLoad) begin
      holdVld  <= 1'b1;
      holdWord <= holdNext;
    end else if (holdClear) begin
      holdVld  <= 1'b0;
    end
  end

  // Registered upstream ready from current buffer occupancy.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) rdyQ <= 1'b0;
    else         rdyQ <= (bufCount <= RDY_LIMIT);
  end

  // Output register toward the switch; fields are zero when not valid.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oWrVld  <= 1'b0;
      oWrSop  <= 1'b0;
      oWrEop  <= 1'b0;
      oWrData <= '0;
    end else begin
      oWrVld  <= pop;
      oWrSop  <= pop && rdWord.sop;
      oWrEop  <= pop && rdWord.eop;
      oWrData <= pop ? rdWord.data : '0;
    end
  end

  // Saturating statistics counters; clear wins over increment.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDropCnt <= '0;
      oErrCnt  <= '0;
      oPktCnt  <= '0;
    end else if (iCntClr) begin
      oDropCnt <= '0;
      oErrCnt  <= '0;
      oPktCnt  <= '0;
    end else begin
      if (incDrop && oDropCnt != '1) oDropCnt <= oDropCnt + 1'b1;
      if (incErr  && oErrCnt  != '1) oErrCnt  <= oErrCnt  + 1'b1;
      if (incPkt  && oPktCnt  != '1) oPktCnt  <= oPktCnt  + 1'b1;
    end
  end

endmodule

// File: tb/tb_ingress_pkt_admit.sv
// Directed bench for ingress_pkt_admit: packets are driven word by word,
// forwarded words are queued as expectations and matched at the switch side.
module tb_ingress_pkt_admit;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              iClk = 1'b0;
  logic              iRst_n = 1'b0;
  logic              iSop = 1'b0;
  logic              iEop = 1'b0;
  logic              iVld = 1'b0;
  logic [DATA_W-1:0] iData = '0;
  logic              oRdy;
  logic              oWrSop;
  logic              oWrEop;
  logic              oWrVld;
  logic [DATA_W-1:0] oWrData;
  logic              iFifoFull = 1'b0;
  logic              iSramAlmostFull = 1'b0;
  logic              iCntClr = 1'b0;
  logic [CNT_W-1:0]  oDropCnt;
  logic [CNT_W-1:0]  oErrCnt;
  logic [CNT_W-1:0]  oPktCnt;

  int total = 0;
  int bad = 0;
  logic [DATA_W+1:0] exp_q[$];

  ingress_pkt_admit #(.DATA_W(DATA_W), .BUF_DEPTH(16), .CNT_W(CNT_W)) dut (
    .iClk            (iClk),
    .iRst_n          (iRst_n),
    .iSop            (iSop),
    .iEop            (iEop),
    .iVld            (iVld),
    .iData           (iData),
    .oRdy            (oRdy),
    .oWrSop          (oWrSop),
    .oWrEop          (oWrEop),
    .oWrVld          (oWrVld),
    .oWrData         (oWrData),
    .iFifoFull       (iFifoFull),
    .iSramAlmostFull (iSramAlmostFull),
    .iCntClr         (iCntClr),
    .oDropCnt        (oDropCnt),
    .oErrCnt         (oErrCnt),
    .oPktCnt         (oPktCnt)
  );

  // Clock
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every switch-side word must match the head of exp_q.
  always @(negedge iClk) begin
    if (iRst_n) begin
      if (oWrVld) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_word observed=%h expected=none", {oWrSop, oWrEop, oWrData});
        end else begin
          check("out_word", {6'd0, oWrSop, oWrEop, oWrData}, {6'd0, exp_q.pop_front()});
        end
      end else begin
        check("idle_zero", {6'd0, oWrSop, oWrEop, oWrData}, 40'd0);
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Holds a word on the input until an edge sees oRdy high.
  task automatic sendWord(input logic s, input logic e, input logic [DATA_W-1:0] d,
                          input logic af);
    logic acc;
    int   n;
    n = 0;
    iSop = s; iEop = e; iData = d; iSramAlmostFull = af; iVld = 1'b1;
    do begin
      acc = oRdy;
      tick();
      n++;
    end while (!acc && n < 500);
    if (!acc) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=no_accept expected=accept data=%h", d);
    end
  endtask

  task automatic idleIn();
    iVld = 1'b0; iSop = 1'b0; iEop = 1'b0; iData = '0;
  endtask

  // Sends an n-word packet; afSop applies to the SOP word, afRest to the others.
  task automatic sendPkt(input int n, input logic [DATA_W-1:0] base, input logic afSop,
                         input logic afRest, input bit fwd);
    for (int i = 0; i < n; i++) begin
      logic s, e;
      s = (i == 0);
      e = (i == n - 1);
      if (fwd) exp_q.push_back({s, e, base + DATA_W'(i)});
      sendWord(s, e, base + DATA_W'(i), s ? afSop : afRest);
    end
    idleIn();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check(tag, 40'(exp_q.size()), 40'd0);
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    check("rst_rdy", 40'(oRdy), 40'd0);
    check("rst_wrvld", 40'(oWrVld), 40'd0);
    check("rst_cnts", {oDropCnt, oErrCnt, oPktCnt[7:0]}, 40'd0);
    iRst_n = 1'b1;
    tick();
    check("rdy_after_rst", 40'(oRdy), 40'd1);

    // 4-word packet forwarded intact
    sendPkt(4, 32'h0000_1000, 1'b0, 1'b0, 1'b1);
    drain("pkt4_drain");
    check("pkt4_pktcnt", 40'(oPktCnt), 40'd1);

    // Dropped 5-word packet, then a packet whose flag rises only after SOP
    sendPkt(5, 32'h0000_2000, 1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    check("drop_dropcnt", 40'(oDropCnt), 40'd1);
    check("drop_pktcnt", 40'(oPktCnt), 40'd1);
    sendPkt(3, 32'h0000_3000, 1'b0, 1'b1, 1'b1);
    drain("after_drop_drain");
    check("after_drop_pktcnt", 40'(oPktCnt), 40'd2);

    // Single-word packet latency: valid exactly two cycles after acceptance
    exp_q.push_back({1'b1, 1'b1, 32'hA5A5_A5A5});
    sendWord(1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0);
    idleIn();
    check("single_lat0", 40'(oWrVld), 40'd0);
    tick();
    check("single_lat1", 40'(oWrVld), 40'd0);
    tick();
    check("single_lat2", {5'd0, oWrVld, oWrSop, oWrEop, oWrData},
          {5'd0, 3'b111, 32'hA5A5_A5A5});
    drain("single_drain");
    check("single_pktcnt", 40'(oPktCnt), 40'd3);

    // Missing EOP on A: A2 closed with forced eop, B intact
    exp_q.push_back({1'b1, 1'b0, 32'h0000_A000});
    exp_q.push_back({1'b0, 1'b0, 32'h0000_A001});
    exp_q.push_back({1'b0, 1'b1, 32'h0000_A002});
    exp_q.push_back({1'b1, 1'b0, 32'h0000_B000});
    exp_q.push_back({1'b0, 1'b0, 32'h0000_B001});
    exp_q.push_back({1'b0, 1'b1, 32'h0000_B002});
    sendWord(1'b1, 1'b0, 32'h0000_A000, 1'b0);
    sendWord(1'b0, 1'b0, 32'h0000_A001, 1'b0);
    sendWord(1'b0, 1'b0, 32'h0000_A002, 1'b0);
    sendWord(1'b1, 1'b0, 32'h0000_B000, 1'b0);
    sendWord(1'b0, 1'b0, 32'h0000_B001, 1'b0);
    sendWord(1'b0, 1'b1, 32'h0000_B002, 1'b0);
    idleIn();
    drain("noeop_drain");
    check("noeop_errcnt", 40'(oErrCnt), 40'd1);
    check("noeop_pktcnt", 40'(oPktCnt), 40'd5);

    // SOP while dropping: error, then re-admitted
    sendWord(1'b1, 1'b0, 32'h0000_5000, 1'b1);
    sendWord(1'b0, 1'b0, 32'h0000_5001, 1'b1);
    sendPkt(2, 32'h0000_6000, 1'b0, 1'b0, 1'b1);
    drain("dropsop_drain");
    check("dropsop_cnts", {oDropCnt[7:0], oErrCnt[7:0], oPktCnt[7:0]},
          {16'd0, 8'd2, 8'd2, 8'd6});

    // Stray word in IDLE is discarded and counted
    sendWord(1'b0, 1'b0, 32'h0000_7777, 1'b0);
    idleIn();
    repeat (3) tick();
    check("stray_errcnt", 40'(oErrCnt), 40'd3);

    // Backpressure for 20 cycles during a 32-word packet
    fork
      sendPkt(32, 32'h0000_8000, 1'b0, 1'b0, 1'b1);
      begin
        iFifoFull = 1'b1;
        repeat (20) tick();
        check("stall_rdy_low", 40'(oRdy), 40'd0);
        iFifoFull = 1'b0;
      end
    join
    drain("stall_drain");
    check("stall_pktcnt", 40'(oPktCnt), 40'd7);

    // Counter clear
    iCntClr = 1'b1;
    tick();
    iCntClr = 1'b0;
    check("clr_cnts", {oDropCnt, oErrCnt, oPktCnt[7:0]}, 40'd0);

    // Reset mid-packet with words held in the buffer
    iFifoFull = 1'b1;
    sendWord(1'b1, 1'b0, 32'h0000_9000, 1'b0);
    sendWord(1'b0, 1'b0, 32'h0000_9001, 1'b0);
    sendWord(1'b0, 1'b0, 32'h0000_9002, 1'b0);
    idleIn();
    tick();
    check("pre_rst_pktcnt", 40'(oPktCnt), 40'd1);
    iRst_n = 1'b0;
    #1;
    check("midrst_outs", {oRdy, oWrVld, oWrSop, oWrEop, oPktCnt, 20'd0}, 40'd0);
    tick();
    iRst_n = 1'b1;
    iFifoFull = 1'b0;
    tick();
    check("midrst_rdy", 40'(oRdy), 40'd1);
    sendPkt(3, 32'h0000_C000, 1'b0, 1'b0, 1'b1);
    drain("midrst_drain");
    check("midrst_pktcnt", 40'(oPktCnt), 40'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
